multdiv_seq: RTL

- Multi-cycle signed 32-bit multiply/divide unit. It sits beside the single-cycle ALU in the execute stage.
- Takes operands on the same data_operandA/data_operandB buses, returns data_result plus an exception flag.
- Uses a one-cycle start pulse and a one-cycle ready pulse, so the pipeline can stall on it.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_addsub.sv | 13 +
 rtl/multdiv_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and iteration counts for multdiv_seq (MULTDIV_BOOTH_EN selects radix-4 multiply)
package multdiv_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } stateT;
`ifdef MULTDIV_BOOTH_EN
  localparam int MULT_ITERS = 16;
`else
  localparam int MULT_ITERS = 32;
`endif
  localparam int DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN = 32'h80000000;
endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: shared adder/subtractor with carry-out (cout=1 on subtract means a >= b)
module multdiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  // Subtraction is a + ~b + 1 so one carry chain serves both operations
  always_comb {cout, sum} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed multiply/divide; define MULTDIV_BOOTH_EN for radix-4 Booth multiply
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULTDIV_BOOTH_EN
  // Booth adds +-2*multiplicand to a signed partial sum, which needs one extra bit of headroom
  localparam int AW = WIDTH + 2;
  localparam int HW = AW;
`else
  localparam int AW = WIDTH + 1;
  localparam int HW = WIDTH;
`endif

  stateT state, nextState;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opReg, lo, nextLo, magA, magB, quot;
  logic [HW-1:0] hi, nextHi;
  logic [WIDTH:0] shifted;
  logic [2*WIDTH-1:0] prod;
  logic [AW-1:0] addA, addB, addSum;
  logic addSub, addCout, negRes, divZero, startMult, startDiv, lastIter, multExc, divExc;
`ifdef MULTDIV_BOOTH_EN
  logic boothBit, nextBooth;
  logic [2:0] dig;
  logic [AW-1:0] mc, boothSum;
`endif

  assign magA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign magB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign startMult = ctrl_MULT & ~ctrl_DIV;
  assign startDiv = ctrl_DIV & ~ctrl_MULT;
  assign lastIter = (state == MULT && cnt == CW'(MULT_ITERS - 1)) || (state == DIV && cnt == CW'(DIV_ITERS - 1));
  assign data_resultRDY = state == DONE;
  assign busy = state != IDLE;

  multdiv_addsub #(.W(AW)) uAddSub (
    .a(addA),
    .b(addB),
    .sub(addSub),
    .sum(addSum),
    .cout(addCout)
  );

  // One iteration step: restoring-divide by default, overridden by the multiply step in MULT
  always_comb begin
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    addA = AW'(shifted);
    addB = AW'(opReg);
    addSub = 1'b1;
    nextHi = addCout ? HW'(addSum[WIDTH-1:0]) : HW'(shifted[WIDTH-1:0]);
    nextLo = {lo[WIDTH-2:0], addCout};
`ifdef MULTDIV_BOOTH_EN
    dig = {lo[1:0], boothBit};
    mc = {{(AW - WIDTH){opReg[WIDTH-1]}}, opReg};
    boothSum = (dig == 3'b000 || dig == 3'b111) ? hi : addSum;
    nextBooth = boothBit;
    if (state == MULT) begin
      addA = hi;
      addB = (dig == 3'b011 || dig == 3'b100) ? mc << 1 : mc;
      addSub = dig[2];
      nextHi = {{2{boothSum[AW-1]}}, boothSum[AW-1:2]};
      nextLo = {boothSum[1:0], lo[WIDTH-1:2]};
      nextBooth = lo[1];
    end
    prod = {nextHi[WIDTH-1:0], nextLo};
`else
    if (state == MULT) begin
      addA = AW'(hi);
      addSub = 1'b0;
      nextHi = lo[0] ? addSum[WIDTH:1] : {1'b0, hi[WIDTH-1:1]};
      nextLo = {lo[0] ? addSum[0] : hi[0], lo[WIDTH-1:1]};
    end
    prod = negRes ? -{nextHi, nextLo} : {nextHi, nextLo};
`endif
    multExc = ~(&prod[2*WIDTH-1:WIDTH-1] | ~|prod[2*WIDTH-1:WIDTH-1]);
    quot = divZero ? '0 : negRes ? -nextLo : nextLo;
    divExc = divZero | (~negRes & nextLo == INT_MIN);
  end

  // Next state: start only on exactly one ctrl pulse while idle
  always_comb begin
    nextState = state == IDLE ? (startMult ? MULT : startDiv ? DIV : IDLE) :
                state == DONE ? IDLE : lastIter ? DONE : state;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end

  // Operand latch, iteration registers and held result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      opReg <= '0;
      lo <= '0;
      hi <= '0;
      negRes <= 1'b0;
      divZero <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
      boothBit <= 1'b0;
`endif
    end else if (state == IDLE && (startMult || startDiv)) begin
      // A zero divisor skips straight to the final step so RDY follows the next edge
      cnt <= (startDiv && data_operandB == '0) ? CW'(DIV_ITERS - 1) : '0;
      divZero <= startDiv && data_operandB == '0;
      negRes <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      hi <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
      boothBit <= 1'b0;
      opReg <= startMult ? data_operandA : magB;
      lo <= startMult ? data_operandB : magA;
`else
      opReg <= startMult ? magA : magB;
      lo <= startMult ? magB : magA;
`endif
    end else if (state == MULT || state == DIV) begin
      cnt <= cnt + 1'b1;
      hi <= nextHi;
      lo <= nextLo;
`ifdef MULTDIV_BOOTH_EN
      boothBit <= nextBooth;
`endif
      if (lastIter) begin
        data_result <= state == MULT ? prod[WIDTH-1:0] : quot;
        data_exception <= state == MULT ? multExc : divExc;
      end
    end
  end
endmodule
